// File: rtl/bcs_serial_comparator.sv
// Bit-serial unsigned magnitude comparator, operands streamed LSB first.
// Result flags are registered and held until the next comparison completes.
module bcs_serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic e1,
    output logic g1
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          eq_r;
    logic          eq_nx;
    logic          gt_r;
    logic          gt_nx;
    logic          busy_nx;
    logic          done_nx;
    logic          e1_nx;
    logic          g1_nx;
    logic          accept;
    logic          last;

    assign accept = (state == SHIFT) && bit_valid;
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (accept && last) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Later (more significant) differing bits override earlier ones.
    always_comb begin
        cnt_nx = cnt;
        eq_nx  = eq_r;
        gt_nx  = gt_r;
        if (state == IDLE && start) begin
            cnt_nx = '0;
            eq_nx  = 1'b1;
            gt_nx  = 1'b0;
        end else if (accept) begin
            cnt_nx = cnt + CW'(1);
            if (a_bit != b_bit) begin
                eq_nx = 1'b0;
                gt_nx = a_bit;
            end
        end
    end

    // Outputs are computed one cycle early so they leave straight from flops.
    always_comb begin
        busy_nx = (state_nx == SHIFT);
        done_nx = (state_nx == FIN);
        e1_nx   = e1;
        g1_nx   = g1;
        if (accept && last) begin
            e1_nx = eq_nx;
            g1_nx = gt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            eq_r <= 1'b1;
            gt_r <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            e1   <= 1'b0;
            g1   <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            eq_r <= eq_nx;
            gt_r <= gt_nx;
            busy <= busy_nx;
            done <= done_nx;
            e1   <= e1_nx;
            g1   <= g1_nx;
        end
    end

endmodule
